// File: rtl/bomb_countdown_timer.sv
// Game countdown timer: turns 1 ms ticks into seconds and counts the remaining game time
// down from at most 9:59. Applies wrong-wire penalties and reports expiry or defusal.
//
// state   | meaning
// IDLE    | time loaded, waiting for start
// RUN     | counting down
// PAUSED  | frozen; the partial second in ms_cnt is kept
// EXPIRED | time ran out (terminal until load)
// DEFUSED | bomb defused (terminal until load)
module bomb_countdown_timer #(
    parameter int MS_PER_SEC   = 1000,
    parameter int PENALTY_SECS = 10,
    parameter int INIT_SECS    = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ms_tick,
    input  logic       load,
    input  logic [9:0] load_secs,
    input  logic       start,
    input  logic       pause,
    input  logic       penalty,
    input  logic       defuse,
    output logic [9:0] time_secs,
    output logic [3:0] min_o,
    output logic [3:0] sec_tens_o,
    output logic [3:0] sec_ones_o,
    output logic       running,
    output logic       expired,
    output logic       defused_o,
    output logic       sec_pulse
);

    localparam int MS_CNT_W = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
    localparam logic [MS_CNT_W-1:0] MS_LAST = MS_CNT_W'(MS_PER_SEC - 1);
    localparam logic [10:0] PEN_SECS = 11'(PENALTY_SECS);
    localparam logic [9:0]  MAX_SECS = 10'd599;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PAUSED,
        EXPIRED,
        DEFUSED
    } state_t;

    state_t              state_q, state_d;
    logic [9:0]          time_q, time_d;
    logic [MS_CNT_W-1:0] ms_cnt_q, ms_cnt_d;
    logic                sec_pulse_q, sec_pulse_d;

    logic                wrap;
    logic [10:0]         dec;
    logic [9:0]          time_sub;
    logic [9:0]          load_clamped;

    assign wrap         = ms_tick && (ms_cnt_q == MS_LAST);
    assign dec          = (penalty ? PEN_SECS : 11'd0) + {10'd0, wrap};
    // Saturating subtract: a penalty larger than the remaining time lands on 0, never wraps.
    assign time_sub     = ({1'b0, time_q} > dec) ? (time_q - dec[9:0]) : 10'd0;
    assign load_clamped = (load_secs > MAX_SECS) ? MAX_SECS : load_secs;

    always_comb begin
        state_d     = state_q;
        time_d      = time_q;
        ms_cnt_d    = ms_cnt_q;
        sec_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    time_d = load_clamped;
                end
                if (start) begin
                    ms_cnt_d = '0;
                    state_d  = (time_q == 10'd0) ? EXPIRED : RUN;
                end
            end
            RUN: begin
                if (defuse) begin
                    state_d = DEFUSED;
                end else if (pause) begin
                    state_d = PAUSED;
                end else begin
                    if (ms_tick) begin
                        ms_cnt_d = wrap ? '0 : ms_cnt_q + MS_CNT_W'(1);
                    end
                    sec_pulse_d = wrap;
                    time_d      = time_sub;
                    if (time_sub == 10'd0) begin
                        state_d = EXPIRED;
                    end
                end
            end
            PAUSED: begin
                if (defuse) begin
                    state_d = DEFUSED;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            EXPIRED, DEFUSED: begin
                if (load) begin
                    time_d   = load_clamped;
                    ms_cnt_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            time_q      <= 10'(INIT_SECS);
            ms_cnt_q    <= '0;
            sec_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_q      <= time_d;
            ms_cnt_q    <= ms_cnt_d;
            sec_pulse_q <= sec_pulse_d;
        end
    end

    assign time_secs  = time_q;
    assign running    = (state_q == RUN);
    assign expired    = (state_q == EXPIRED);
    assign defused_o  = (state_q == DEFUSED);
    assign sec_pulse  = sec_pulse_q;

    // Display digits follow time_secs within the same cycle.
    assign min_o      = 4'(time_q / 10'd60);
    assign sec_tens_o = 4'((time_q % 10'd60) / 10'd10);
    assign sec_ones_o = 4'(time_q % 10'd10);

endmodule

// File: tb/tb_bomb_countdown_timer.sv
// Directed bench for bomb_countdown_timer with MS_PER_SEC=4, PENALTY_SECS=10, INIT_SECS=300.
module tb_bomb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ms_tick = 1'b0;
    logic       load = 1'b0;
    logic [9:0] load_secs = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       penalty = 1'b0;
    logic       defuse = 1'b0;
    logic [9:0] time_secs;
    logic [3:0] min_o, sec_tens_o, sec_ones_o;
    logic       running, expired, defused_o, sec_pulse;

    int checks = 0;
    int errors = 0;

    bomb_countdown_timer #(
        .MS_PER_SEC  (4),
        .PENALTY_SECS(10),
        .INIT_SECS   (300)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ms_tick    (ms_tick),
        .load       (load),
        .load_secs  (load_secs),
        .start      (start),
        .pause      (pause),
        .penalty    (penalty),
        .defuse     (defuse),
        .time_secs  (time_secs),
        .min_o      (min_o),
        .sec_tens_o (sec_tens_o),
        .sec_ones_o (sec_ones_o),
        .running    (running),
        .expired    (expired),
        .defused_o  (defused_o),
        .sec_pulse  (sec_pulse)
    );

    always #5 clk = ~clk;

    // Advance n clock edges; inputs change and outputs are sampled 1 ns after the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_digits(input string tag, input int m, input int t, input int o);
        chk({tag, "_min"},  {28'd0, min_o},      m);
        chk({tag, "_tens"}, {28'd0, sec_tens_o}, t);
        chk({tag, "_ones"}, {28'd0, sec_ones_o}, o);
    endtask

    task automatic ticks(input int n);
        ms_tick = 1'b1;
        cyc(n);
        ms_tick = 1'b0;
    endtask

    task automatic do_load(input int secs);
        load_secs = 10'(secs);
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state and first second
        cyc(2);
        rst = 1'b0;
        chk("rst_time", {22'd0, time_secs}, 300);
        chk_digits("rst", 5, 0, 0);
        chk("rst_running", {31'd0, running}, 0);
        chk("rst_expired", {31'd0, expired}, 0);
        chk("rst_defused", {31'd0, defused_o}, 0);
        chk("rst_pulse", {31'd0, sec_pulse}, 0);
        ticks(3);
        chk("idle_tick_ignored", {22'd0, time_secs}, 300);
        do_start();
        chk("start_running", {31'd0, running}, 1);
        ticks(3);
        chk("three_ticks_time", {22'd0, time_secs}, 300);
        chk("three_ticks_pulse", {31'd0, sec_pulse}, 0);
        ticks(1);
        chk("first_sec_time", {22'd0, time_secs}, 299);
        chk("first_sec_pulse", {31'd0, sec_pulse}, 1);
        chk_digits("first_sec", 4, 5, 9);
        cyc(1);
        chk("pulse_one_cycle", {31'd0, sec_pulse}, 0);

        // Expiry
        do_reset();
        do_load(2);
        chk("load2_time", {22'd0, time_secs}, 2);
        do_start();
        ticks(4);
        chk("exp_step1", {22'd0, time_secs}, 1);
        chk("exp_step1_running", {31'd0, running}, 1);
        ticks(3);
        chk("exp_pre_zero", {22'd0, time_secs}, 1);
        chk("exp_pre_zero_expired", {31'd0, expired}, 0);
        ticks(1);
        chk("exp_zero_time", {22'd0, time_secs}, 0);
        chk("exp_zero_expired", {31'd0, expired}, 1);
        chk("exp_zero_running", {31'd0, running}, 0);
        chk_digits("exp_zero", 0, 0, 0);
        ticks(4);
        chk("exp_hold_time", {22'd0, time_secs}, 0);
        chk("exp_hold_expired", {31'd0, expired}, 1);
        chk("exp_hold_pulse", {31'd0, sec_pulse}, 0);

        // Penalty saturation (load from EXPIRED returns to IDLE)
        do_load(15);
        chk("pen_load_expired", {31'd0, expired}, 0);
        chk("pen_load_time", {22'd0, time_secs}, 15);
        do_start();
        penalty = 1'b1;
        cyc(1);
        penalty = 1'b0;
        chk("pen1_time", {22'd0, time_secs}, 5);
        chk("pen1_pulse", {31'd0, sec_pulse}, 0);
        penalty = 1'b1;
        cyc(1);
        penalty = 1'b0;
        chk("pen2_time_sat", {22'd0, time_secs}, 0);
        chk("pen2_expired", {31'd0, expired}, 1);

        // Simultaneous penalty and wrapping tick
        do_load(100);
        do_start();
        ticks(3);
        ms_tick = 1'b1;
        penalty = 1'b1;
        cyc(1);
        ms_tick = 1'b0;
        penalty = 1'b0;
        chk("simul_time", {22'd0, time_secs}, 89);
        chk("simul_pulse", {31'd0, sec_pulse}, 1);
        chk_digits("simul", 1, 2, 9);
        cyc(1);
        chk("simul_pulse_once", {31'd0, sec_pulse}, 0);

        // Pause / resume keeps the partial second
        do_reset();
        do_load(10);
        do_start();
        ticks(2);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        chk("pause_running", {31'd0, running}, 0);
        ticks(5);
        penalty = 1'b1;
        cyc(1);
        penalty = 1'b0;
        chk("paused_time", {22'd0, time_secs}, 10);
        do_start();
        chk("resume_running", {31'd0, running}, 1);
        ticks(1);
        chk("resume_one_tick", {22'd0, time_secs}, 10);
        ticks(1);
        chk("resume_time", {22'd0, time_secs}, 9);
        chk("resume_pulse", {31'd0, sec_pulse}, 1);

        // Defuse beats penalty; terminal until load; load clamps
        do_reset();
        do_load(50);
        do_start();
        defuse = 1'b1;
        penalty = 1'b1;
        cyc(1);
        defuse = 1'b0;
        penalty = 1'b0;
        chk("defuse_flag", {31'd0, defused_o}, 1);
        chk("defuse_time", {22'd0, time_secs}, 50);
        chk("defuse_running", {31'd0, running}, 0);
        ticks(6);
        do_start();
        chk("defuse_hold_time", {22'd0, time_secs}, 50);
        chk("defuse_hold_flag", {31'd0, defused_o}, 1);
        do_load(700);
        chk("clamp_defused", {31'd0, defused_o}, 0);
        chk("clamp_running", {31'd0, running}, 0);
        chk("clamp_time", {22'd0, time_secs}, 599);
        chk_digits("clamp", 9, 5, 9);

        // Start with zero time goes straight to EXPIRED
        do_load(0);
        do_start();
        chk("zero_start_expired", {31'd0, expired}, 1);
        chk("zero_start_running", {31'd0, running}, 0);

        // Reset mid-RUN wins over a wrapping tick
        do_load(20);
        do_start();
        ticks(3);
        ms_tick = 1'b1;
        rst = 1'b1;
        cyc(1);
        ms_tick = 1'b0;
        rst = 1'b0;
        chk("midrst_time", {22'd0, time_secs}, 300);
        chk("midrst_pulse", {31'd0, sec_pulse}, 0);
        chk("midrst_running", {31'd0, running}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bomb_countdown_timer.md
# bomb_countdown_timer

Game countdown timer that consumes the 1 ms timeout pulse from the millisecond tick generator. It counts ticks into seconds, holds the remaining game time (0:00 to 9:59), applies wrong-wire penalties, and reports expiry or defusal to the game FSM. Its minute and second digits drive the seven-segment display stage directly.

## Interface
- `MS_PER_SEC`, default 1000: ticks per second. Set it small, e.g. 4, for simulation.
- `PENALTY_SECS`, default 10: seconds removed per penalty pulse.
- `INIT_SECS`, default 300: time loaded at reset, as binary seconds (5:00).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- `ms_tick`  in  1  one-cycle pulse every 1 ms from the upstream tick generator.
- `load`  in  1  one-cycle pulse: load `load_secs`.
- `load_secs`  in  10  binary seconds to load; values above 599 clamp to 599.
- `start`  in  1  one-cycle pulse: start or resume the countdown.
- `pause`  in  1  one-cycle pulse: freeze the countdown.
- `penalty`  in  1  one-cycle pulse: subtract `PENALTY_SECS`.
- `defuse`  in  1  one-cycle pulse: bomb defused.
- `time_secs`  out  10  remaining seconds, binary, registered.
- `min_o`  out  4  minutes digit (0-9), combinational from `time_secs`.
- `sec_tens_o`  out  4  tens-of-seconds digit (0-5).
- `sec_ones_o`  out  4  ones-of-seconds digit (0-9).
- `running`  out  1  high in RUN.
- `expired`  out  1  level, high in EXPIRED.
- `defused_o`  out  1  level, high in DEFUSED.
- `sec_pulse`  out  1  one-cycle pulse on each 1 s decrement; drives the beeper.

## Operation
- Internal state: a 10-bit `time_secs` register and a `ms_cnt` register wide enough to hold `MS_PER_SEC-1`.
- States are IDLE, RUN, PAUSED, EXPIRED and DEFUSED.
- Reset:
  - state IDLE, `time_secs`=`INIT_SECS`, `ms_cnt`=0;
  - `running`, `expired`, `defused_o` and `sec_pulse` all 0.
- IDLE:
  - `load` writes the clamped `load_secs` into `time_secs`.
  - `start` clears `ms_cnt` and goes to RUN. If `time_secs` is 0, `start` goes to EXPIRED instead.
  - `ms_tick`, `pause`, `penalty` and `defuse` are ignored.
- RUN, per cycle, in priority order:
  - `defuse` goes to DEFUSED, and `time_secs` freezes.
  - Otherwise `pause` goes to PAUSED, and `ms_cnt` is held.
  - Otherwise compute the decrement `d`. `d` is `PENALTY_SECS` if `penalty` is high, plus 1 if `ms_tick` is high and `ms_cnt`==`MS_PER_SEC-1`.
  - On such a wrapping tick, `ms_cnt` goes to 0 and `sec_pulse`=1 next cycle. On any other `ms_tick`, `ms_cnt` increments.
  - `time_secs` becomes `time_secs`-`d`, saturating at 0.
  - If the new value is 0, the next state is EXPIRED.
- PAUSED:
  - `start` goes to RUN with `ms_cnt` preserved, so the partial second is kept.
  - `defuse` goes to DEFUSED, with priority over `start`.
  - `ms_tick` and `penalty` are ignored.
- EXPIRED and DEFUSED are terminal:
  - all inputs are ignored except `load`;
  - `load` writes `time_secs`, clears `ms_cnt` and goes to IDLE.
- `load` in RUN or PAUSED is ignored.
- `start` in RUN and `pause` outside RUN are no-ops.
- Digit conversion:
  - `min_o` = `time_secs`/60;
  - `sec_tens_o` = (`time_secs` mod 60)/10;
  - `sec_ones_o` = `time_secs` mod 10;
  - all purely combinational, so the digits always match `time_secs` in the same cycle.

## Timing
- All outputs except the digits are registered, so each takes effect exactly one cycle after its sampled input edge.
- Start: `start` sampled at edge N gives `running`=1 after edge N. `ms_tick` is counted from edge N+1 onward.
- First decrement comes `MS_PER_SEC` ticks after start. `sec_pulse` and the new `time_secs` appear together, one cycle after the wrapping tick edge.
- Expiry: on the edge where `time_secs` reaches 0, `expired`=1 and `running`=0 on the same edge. The display reads 0:00 together with `expired`.
- Simultaneous penalty and wrapping tick: one combined subtraction of `PENALTY_SECS`+1 on a single edge, with one `sec_pulse`.
- Reset wins over every input. Asserting `rst` mid-RUN restores `INIT_SECS` and IDLE on the next edge, and `sec_pulse` is 0 that cycle.

## Test plan
- **Reset:** `MS_PER_SEC`=4. Assert `rst`, then `start`. Expect:
  - `time_secs`=300 and digits 5/0/0 before `start`;
  - after 4 ticks, `time_secs`=299, digits 4/5/9, and one `sec_pulse`.
- **Expiry:** load 2, start, apply 8 ticks. Expect:
  - `time_secs` steps 2→1→0;
  - `expired`=1 on the same edge `time_secs` reaches 0, `running`=0;
  - further ticks leave everything unchanged.
- **Penalty saturation:** load 15, start.
  - `penalty` with no tick: `time_secs`=5.
  - A second `penalty`: `time_secs`=0 and `expired`=1 (saturates, no wrap to 1019).
- **Simultaneous events:** load 100, start, give 3 ticks.
  - On the 4th tick, pulse `penalty` in the same cycle: `time_secs`=89 and exactly one `sec_pulse`.
- **Pause/resume:** load 10, start, 2 ticks, then `pause`.
  - 5 ticks while paused: `time_secs` stays 10.
  - `start`, then 2 more ticks: `time_secs`=9.
- **Defuse and terminal state:** load 50, start, assert `defuse` and `penalty` in the same cycle. Expect:
  - `defused_o`=1 and `time_secs` stays 50;
  - a later `load` with `load_secs`=700 gives IDLE and `time_secs`=599 (digits 9/5/9).
